// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one BCD decoder.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LZ_SUPPRESS_EN.
module seg_scan_ctrl #(
    parameter int unsigned N_DIGITS      = 4,
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter int unsigned BLANK_CYC     = 500,
    parameter bit          AN_ACTIVE_LOW = 1'b1,
    localparam int unsigned IDX_W        = $clog2(N_DIGITS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  load,
    output logic                  pending,
    output logic                  frame_start,
    output logic [IDX_W-1:0]      digit_idx,
    output logic [3:0]            bcd_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   an
);

    localparam int unsigned TICK_W = $clog2(REFRESH_DIV);
    localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] BIT0   = {{(N_DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t                       state, nxt_state;
    logic                         run;
    logic [TICK_W-1:0]            tick_cnt, nxt_tick;
    logic [IDX_W-1:0]             nxt_idx;
    logic [N_DIGITS-1:0][3:0]     active_val, nxt_act_val, pend_val;
    logic [N_DIGITS-1:0]          active_dp, nxt_act_dp, pend_dp;
    logic                         nxt_pending, nxt_frame_start, commit;
    logic [3:0]                   nxt_bcd;
    logic                         nxt_dp_out;
    logic [N_DIGITS-1:0]          nxt_an, sel_onehot, lit_mask;

    // Slot timing, commit decision and the output values for the upcoming cycle
    always_comb begin
        nxt_tick        = tick_cnt;
        nxt_idx         = digit_idx;
        nxt_state       = state;
        nxt_frame_start = 1'b0;
        commit          = 1'b0;

        if (!run) begin
            // First edge after reset release enters tick 0 of slot 0
            nxt_tick        = '0;
            nxt_idx         = '0;
            nxt_state       = BLANK;
            nxt_frame_start = 1'b1;
        end else if (tick_cnt == TICK_W'(REFRESH_DIV - 1)) begin
            nxt_tick  = '0;
            nxt_state = BLANK;
            if (digit_idx == IDX_W'(N_DIGITS - 1)) begin
                nxt_idx         = '0;
                nxt_frame_start = 1'b1;
                commit          = pending;
            end else begin
                nxt_idx = digit_idx + 1'b1;
            end
        end else begin
            nxt_tick = tick_cnt + 1'b1;
            if (tick_cnt + 1'b1 == TICK_W'(BLANK_CYC)) begin
                nxt_state = SHOW;
            end
        end

        nxt_act_val = active_val;
        nxt_act_dp  = active_dp;
        if (commit) begin
            nxt_act_val = pend_val;
            nxt_act_dp  = pend_dp;
        end

        nxt_pending = pending;
        if (load) begin
            nxt_pending = 1'b1;
        end else if (commit) begin
            nxt_pending = 1'b0;
        end

        // bcd leads the anode so the decoder settles during the blank
        nxt_bcd    = nxt_act_val[nxt_idx];
        sel_onehot = BIT0 << nxt_idx;
        nxt_an     = AN_OFF;
        nxt_dp_out = 1'b1;
        if (nxt_state == SHOW) begin
            nxt_dp_out = ~nxt_act_dp[nxt_idx];
            if (lit_mask[nxt_idx]) begin
                nxt_an = AN_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
            end
        end
    end

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    // A digit is dark when it and all higher digits are zero and its dp is off
    logic [N_DIGITS-1:0] nib_zero, zero_run;

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_lz
        assign nib_zero[g] = (nxt_act_val[g] == 4'd0);
        if (g == N_DIGITS - 1) begin : g_top
            assign zero_run[g] = nib_zero[g];
        end else begin : g_low
            assign zero_run[g] = nib_zero[g] & zero_run[g+1];
        end
    end

    assign lit_mask = ~(zero_run & ~nxt_act_dp) | BIT0;
`else
    assign lit_mask = '1;
`endif

    // State, counters, buffers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            state       <= BLANK;
            tick_cnt    <= '0;
            digit_idx   <= '0;
            active_val  <= '0;
            active_dp   <= '0;
            pend_val    <= '0;
            pend_dp     <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
            bcd_out     <= 4'd0;
            dp_out      <= 1'b1;
            an          <= AN_OFF;
        end else begin
            run         <= 1'b1;
            state       <= nxt_state;
            tick_cnt    <= nxt_tick;
            digit_idx   <= nxt_idx;
            active_val  <= nxt_act_val;
            active_dp   <= nxt_act_dp;
            pending     <= nxt_pending;
            frame_start <= nxt_frame_start;
            bcd_out     <= nxt_bcd;
            dp_out      <= nxt_dp_out;
            an          <= nxt_an;
            if (load) begin
                pend_val <= value_in;
                pend_dp  <= dp_in;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2).
// Leading-zero expectations follow SEG_SCAN_LZ_SUPPRESS_EN.
module tb_seg_scan_ctrl;

    localparam int unsigned N_DIGITS    = 4;
    localparam int unsigned REFRESH_DIV = 8;
    localparam int unsigned BLANK_CYC   = 2;

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    localparam logic [3:0] LIT_ZERO = 4'b0001;
    localparam logic [3:0] LIT_0045 = 4'b0011;
`else
    localparam logic [3:0] LIT_ZERO = 4'b1111;
    localparam logic [3:0] LIT_0045 = 4'b1111;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        pending;
    logic        frame_start;
    logic [1:0]  digit_idx;
    logic [3:0]  bcd_out;
    logic        dp_out;
    logic [3:0]  an;

    int n_checks;
    int n_errors;
    int cyc;

    seg_scan_ctrl #(
        .N_DIGITS     (N_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYC    (BLANK_CYC),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .load       (load),
        .pending    (pending),
        .frame_start(frame_start),
        .digit_idx  (digit_idx),
        .bcd_out    (bcd_out),
        .dp_out     (dp_out),
        .an         (an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // All sampling and driving happens on the falling edge
    task automatic next_cyc();
        @(negedge clk);
        cyc++;
    endtask

    task automatic advance_to(input int target);
        while (cyc < target) next_cyc();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        next_cyc();
        load     = 1'b0;
    endtask

    // Checks one full frame starting at tick 0 of slot 0
    task automatic run_frame(input string tag, input logic [15:0] val, input logic [3:0] dpv,
                             input logic [3:0] lit);
        logic [3:0] onehot;
        logic [3:0] exp_an;
        int slot, t;
        for (int c = 0; c < 32; c++) begin
            slot   = c / 8;
            t      = c % 8;
            onehot = 4'b0001 << slot;
            exp_an = (t >= 2 && lit[slot]) ? ~onehot : 4'b1111;
            check({tag, "_bcd"}, 32'(bcd_out), 32'(val[slot*4 +: 4]));
            check({tag, "_an"}, 32'(an), 32'(exp_an));
            check({tag, "_dp"}, 32'(dp_out), (t >= 2 && dpv[slot]) ? 32'd0 : 32'd1);
            check({tag, "_idx"}, 32'(digit_idx), 32'(slot));
            check({tag, "_fs"}, 32'(frame_start), (c == 0) ? 32'd1 : 32'd0);
            next_cyc();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = 16'h0;
        dp_in    = 4'h0;

        repeat (2) @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_bcd", 32'(bcd_out), 32'h0);
        check("rst_dp", 32'(dp_out), 32'h1);
        check("rst_pend", 32'(pending), 32'h0);
        check("rst_fs", 32'(frame_start), 32'h0);
        check("rst_idx", 32'(digit_idx), 32'h0);

        // Idle scan after release: digit 0 lit only in SHOW, value zero
        rst_n = 1'b1;
        cyc   = -1;
        next_cyc();
        run_frame("idle", 16'h0000, 4'b0000, LIT_ZERO);
        check("idle_wrap_idx", 32'(digit_idx), 32'd0);
        check("idle_wrap_fs", 32'(frame_start), 32'd1);
        advance_to(40);
        check("idle_idx40", 32'(digit_idx), 32'd1);

        // Load in slot 1; stays pending until the frame wrap
        do_load(16'h1234, 4'b0010);
        check("ld_pend", 32'(pending), 32'd1);
        advance_to(63);
        check("ld_pend63", 32'(pending), 32'd1);
        check("ld_notear", 32'(bcd_out), 32'd0);
        next_cyc();
        check("ld_commit", 32'(pending), 32'd0);
        run_frame("f1234", 16'h1234, 4'b0010, 4'b1111);

        // Two loads in one frame: only the last one is shown
        advance_to(100);
        do_load(16'hAAAA, 4'b0000);
        check("dbl_old_bcd", 32'(bcd_out), 32'd4);
        advance_to(110);
        do_load(16'h5678, 4'b0000);
        check("dbl_pend", 32'(pending), 32'd1);
        advance_to(128);
        run_frame("f5678", 16'h5678, 4'b0000, 4'b1111);

        // Load exactly on the commit edge with another value already pending
        advance_to(170);
        do_load(16'h1111, 4'b0000);
        advance_to(191);
        value_in = 16'h9999;
        dp_in    = 4'b0000;
        load     = 1'b1;
        next_cyc();
        load     = 1'b0;
        check("cedge_pend", 32'(pending), 32'd1);
        run_frame("f1111", 16'h1111, 4'b0000, 4'b1111);
        check("cedge_pend2", 32'(pending), 32'd0);
        run_frame("f9999", 16'h9999, 4'b0000, 4'b1111);

        // Reset mid-SHOW of slot 2 with a value pending
        advance_to(260);
        do_load(16'h7777, 4'b1111);
        advance_to(276);
        check("mid_an_pre", 32'(an), 32'hB);
        rst_n = 1'b0;
        #1;
        check("mid_an", 32'(an), 32'hF);
        check("mid_bcd", 32'(bcd_out), 32'h0);
        check("mid_pend", 32'(pending), 32'h0);
        check("mid_idx", 32'(digit_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = -1;
        next_cyc();
        run_frame("post_rst", 16'h0000, 4'b0000, LIT_ZERO);
        check("post_rst_pend", 32'(pending), 32'd0);

        // Leading zeros: upper digits dark only when suppression is built in
        advance_to(40);
        do_load(16'h0045, 4'b0000);
        advance_to(64);
        run_frame("f0045", 16'h0045, 4'b0000, LIT_0045);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one BCD-to-7-segment decoder.
- Holds a double-buffered display value and steps through the digits at a fixed refresh rate.
- Presents one 4-bit nibble per slot on `bcd_out`, drives the matching anode, and inserts a dead-time blank between digits to suppress ghosting.
- Sits between the system datapath (value producer) and the segment decoder / board pins.

Parameters:
- N_DIGITS, 4, number of digits scanned (≥2).
- REFRESH_DIV, 50000, clock cycles per digit slot (≥ BLANK_CYC+2).
- BLANK_CYC, 500, leading cycles of each slot with all anodes off (≥1).
- AN_ACTIVE_LOW, 1, 1: anode enabled by 0; 0: enabled by 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value_in  in  4*N_DIGITS  nibble k = digit k (digit 0 = rightmost, least significant).
- dp_in  in  N_DIGITS  decimal point per digit, 1 = lit; sampled with `value_in`.
- load  in  1  single-cycle strobe; captures `value_in`/`dp_in` into the pending buffer.
- pending  out  1  1 while a captured value awaits commit.
- frame_start  out  1  one-cycle pulse at the first cycle of the digit-0 slot.
- digit_idx  out  clog2(N_DIGITS)  index of the current slot.
- bcd_out  out  4  nibble for the shared decoder.
- dp_out  out  1  decimal point, active-low (0 = lit).
- an  out  N_DIGITS  anode enables, polarity per AN_ACTIVE_LOW.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - tick_cnt=0, digit_idx=0, state=BLANK.
  - Active and pending buffers cleared; pending=0; frame_start=0.
  - bcd_out=0, dp_out=1, an = all inactive (all 1s if AN_ACTIVE_LOW).
  - Reset mid-scan aborts the slot immediately; no commit occurs.
  - After release: first cycle is tick_cnt=0 of slot 0, and frame_start=1 on that cycle.
- tick_cnt:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - At wrap, digit_idx increments; N_DIGITS-1 → 0.
- State machine, 2 states:
  - BLANK while tick_cnt < BLANK_CYC; SHOW otherwise.
  - BLANK→SHOW when tick_cnt reaches BLANK_CYC.
  - SHOW→BLANK at tick_cnt wrap.
- All outputs are registered and change on the same edge as the state/counter they reflect. There is no combinational path from inputs to outputs.
- In BLANK:
  - an = all inactive.
  - bcd_out already presents active[digit_idx], so the decoder settles before the anode turns on.
- In SHOW:
  - an enables only bit digit_idx.
  - dp_out = ~active_dp[digit_idx].
- Double buffering:
  - load=1 writes the pending buffer and sets pending=1 on the next edge. Latest load wins; repeated loads just overwrite.
  - Commit happens on the edge where digit_idx wraps N_DIGITS-1→0 and pending=1: pending buffer → active buffer, pending cleared.
  - The display therefore never tears within a frame.
  - load on the commit edge: the commit takes the old pending contents, the new value is written to the pending buffer, and pending stays 1.
- frame_start asserts for exactly one cycle: tick_cnt=0 with digit_idx=0.
- No handshake back-pressure; load is always accepted.

Optional Feature:
- Macro: SEG_SCAN_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression.
  - A digit k>0 is blanked (anode kept inactive in SHOW) when it and every digit above it in the active buffer are 0 and its dp bit is 0.
  - Digit 0 is always shown.
  - Slot timing and digit_idx are unchanged.
- Undefined: all digits are always shown; the logic is not compiled.

Test Plan:
Test parameters: N_DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2, AN_ACTIVE_LOW=1.
- Reset then idle 40 cycles → an=4'b1111 for the first 2 cycles, then 4'b1110 for 6 cycles. digit_idx steps 0,1,2,3,0 every 8 cycles. bcd_out=0 throughout.
- load with value_in=16'h1234, dp_in=4'b0010 during slot 1 → pending=1 until the wrap into slot 0, then active. bcd_out sequence is 4,3,2,1. dp_out=0 only in slot 1 SHOW.
- Two loads in one frame, 16'hAAAA then 16'h5678 → next frame displays 8,7,6,5. 16'hAAAA is never displayed.
- load 16'h9999 exactly on the commit edge, with 16'h1111 already pending → the frame shows 1s, the following frame shows 9s; pending stays 1 across that edge.
- rst_n low for 1 cycle mid-SHOW of slot 2 → an=4'b1111 immediately (asynchronous). Restart at slot 0 with frame_start=1. Display is 0.
- With SEG_SCAN_LZ_SUPPRESS_EN defined, load 16'h0045 → slots 2 and 3 keep an=4'b1111 in SHOW; slots 0 and 1 show 5 and 4. Without the macro, all four digits light.
